// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the cpu instruction memory.
// Receives a byte stream (2-byte little-endian word count, then the words
// themselves, little-endian), writes each word to consecutive word addresses
// starting at 0, then releases the cpu by raising cpu_enable.
module imem_loader #(
   parameter int MAX_WORDS = 128
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        start,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
   output logic [63:0] addr_ext,
   output logic        wen_ext,
   output logic [31:0] wdata_ext,
   output logic        cpu_enable,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] word_count
);

   localparam int IW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_LOAD,
      ST_WRITE,
      ST_RUN,
      ST_ERROR
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   word_idx;
   logic [1:0]      byte_idx;
   logic [23:0]     asm_lo;     // bytes 0..2 of the word being assembled
   logic            accept;
   logic [15:0]     hdr_count;
   logic            hdr_bad;
   logic            last_word;

   // s_ready is a registered Moore output, so accept has no path to outputs
   assign accept    = s_valid & s_ready;
   assign hdr_count = {s_data, word_count[7:0]};
   assign hdr_bad   = (hdr_count == 16'd0) || (hdr_count > 16'(MAX_WORDS));
   assign last_word = ({{(16-IW){1'b0}}, word_idx} == (word_count - 16'd1));

   // Next-state selection
   always_comb begin
      // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         ST_IDLE, ST_RUN, ST_ERROR: begin
            if (start) state_nxt = ST_HDR;
         end
         ST_HDR: begin
            if (accept && byte_idx[0]) state_nxt = hdr_bad ? ST_ERROR : ST_LOAD;
         end
         ST_LOAD: begin
            if (accept && (byte_idx == 2'd3)) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            state_nxt = last_word ? ST_RUN : ST_LOAD;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register with Moore outputs registered from the next state
   always_ff @(posedge clk or posedge arst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (arst) begin
         state      <= ST_IDLE;
         s_ready    <= 1'b0;
         wen_ext    <= 1'b0;
         cpu_enable <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         state      <= state_nxt;
         s_ready    <= (state_nxt == ST_HDR) || (state_nxt == ST_LOAD);
         wen_ext    <= (state_nxt == ST_WRITE);
         cpu_enable <= (state_nxt == ST_RUN);
         busy       <= (state_nxt == ST_HDR) || (state_nxt == ST_LOAD) || (state_nxt == ST_WRITE);
         done       <= (state_nxt == ST_RUN);
         error      <= (state_nxt == ST_ERROR);
      end
   end

   // Header capture, byte assembly and write-port registers
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         word_idx   <= '0;
         byte_idx   <= 2'd0;
         asm_lo     <= 24'd0;
         word_count <= 16'd0;
         addr_ext   <= 64'd0;
         wdata_ext  <= 32'd0;
      end else begin
         case (state)
            ST_IDLE, ST_RUN, ST_ERROR: begin
               if (start) begin
                  word_idx   <= '0;
                  byte_idx   <= 2'd0;
                  word_count <= 16'd0;
               end
            end
            ST_HDR: begin
               if (accept) begin
                  if (!byte_idx[0]) begin
                     word_count[7:0] <= s_data;
                     byte_idx        <= 2'd1;
                  end else begin
                     word_count[15:8] <= s_data;
                     byte_idx         <= 2'd0;
                  end
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: asm_lo[7:0]   <= s_data;
                     2'd1: asm_lo[15:8]  <= s_data;
                     2'd2: asm_lo[23:16] <= s_data;
                     default: begin
                        // Final byte: present the complete word for the WRITE cycle
                        wdata_ext <= {s_data, asm_lo};
                        addr_ext  <= {{(62-IW){1'b0}}, word_idx, 2'b00};
                     end
                  endcase
               end
            end
            ST_WRITE: begin
               if (!last_word) word_idx <= word_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
